// File: rtl/ressource_grid_ring_scheduler.sv
// Resource-grid ring scheduler.
// Tracks the ring writer position (segment, offset), counts completed
// segments against CPU consumption, throttles the writer when the ring is
// full and pulses an interrupt on segment completion.
module ressource_grid_ring_scheduler #(
    parameter int NUM_SEGMENTS  = 10,
    parameter int SEGMENT_SIZE  = 240,
    parameter int INT_THRESHOLD = 1,
    localparam int SEG_W  = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1,
    localparam int OFF_W  = (SEGMENT_SIZE > 1) ? $clog2(SEGMENT_SIZE) : 1,
    localparam int FILL_W = $clog2(NUM_SEGMENTS + 1)
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              enable_i,
    input  logic              beat_i,
    input  logic              cpu_consume_i,
    input  logic              clear_errors_i,
    output logic              wr_ready_o,
    output logic [SEG_W-1:0]  wr_segment_o,
    output logic [OFF_W-1:0]  wr_offset_o,
    output logic [SEG_W-1:0]  last_segment_o,
    output logic [FILL_W-1:0] fill_level_o,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              underflow_o,
    output logic              int_o,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } state_t;

    localparam logic [SEG_W-1:0]  LAST_SEG  = SEG_W'(NUM_SEGMENTS - 1);
    localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(SEGMENT_SIZE - 1);
    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NUM_SEGMENTS);
    localparam logic [FILL_W-1:0] INT_LEVEL = FILL_W'(INT_THRESHOLD);

    state_t             state_q;
    state_t             state_d;
    logic               wr_ready_q;
    logic [SEG_W-1:0]   wr_segment_q;
    logic [OFF_W-1:0]   wr_offset_q;
    logic [SEG_W-1:0]   last_segment_q;
    logic [FILL_W-1:0]  fill_q;
    logic [FILL_W-1:0]  fill_d;
    logic               busy_q;
    logic               overflow_q;
    logic               underflow_q;
    logic               int_q;

    logic               valid_beat;
    logic               complete;
    logic               consume_ok;
    logic               overflow_evt;
    logic               underflow_evt;
    logic               ring_full_next;

    // Classify this cycle's events: accepted beats, segment completion,
    // honoured consumes and the two error conditions.
    always_comb begin
        valid_beat     = beat_i & wr_ready_q;
        complete       = valid_beat && (wr_offset_q == LAST_OFF);
        consume_ok     = cpu_consume_i && (fill_q != '0);
        overflow_evt   = beat_i & ~wr_ready_q;
        underflow_evt  = cpu_consume_i && (fill_q == '0);
    end

    // Next fill level; a completion and a consume in one cycle cancel out,
    // and the level is held at the ring size as a safety cap.
    always_comb begin
        fill_d = fill_q;
        if (complete && !consume_ok && (fill_q < FILL_MAX)) begin
            fill_d = fill_q + FILL_W'(1);
        end else if (consume_ok && !complete) begin
            fill_d = fill_q - FILL_W'(1);
        end
        ring_full_next = complete && (fill_d == FILL_MAX);
    end

    // Next-state logic for the writer sequencing FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ring_full_next) begin
                    state_d = FULL;
                end else if (!enable_i) begin
                    if ((wr_offset_q == '0) && !valid_beat) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (ring_full_next) begin
                    state_d = FULL;
                end else if (enable_i) begin
                    state_d = RUN;
                end else if (complete) begin
                    state_d = IDLE;
                end
            end
            FULL: begin
                if (consume_ok) begin
                    state_d = enable_i ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, write pointers, fill level and derived registered outputs.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q        <= IDLE;
            wr_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            wr_segment_q   <= '0;
            wr_offset_q    <= '0;
            last_segment_q <= LAST_SEG;
            fill_q         <= '0;
            int_q          <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ready_q <= (state_d == RUN) || (state_d == DRAIN);
            busy_q     <= (state_d != IDLE);
            fill_q     <= fill_d;
            int_q      <= complete && (fill_d >= INT_LEVEL);
            if (complete) begin
                wr_offset_q    <= '0;
                wr_segment_q   <= (wr_segment_q == LAST_SEG) ? '0 : wr_segment_q + SEG_W'(1);
                last_segment_q <= wr_segment_q;
            end else if (valid_beat) begin
                wr_offset_q <= wr_offset_q + OFF_W'(1);
            end
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear wins.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (overflow_evt) begin
                overflow_q <= 1'b1;
            end else if (clear_errors_i) begin
                overflow_q <= 1'b0;
            end
            if (underflow_evt) begin
                underflow_q <= 1'b1;
            end else if (clear_errors_i) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign wr_ready_o     = wr_ready_q;
    assign wr_segment_o   = wr_segment_q;
    assign wr_offset_o    = wr_offset_q;
    assign last_segment_o = last_segment_q;
    assign fill_level_o   = fill_q;
    assign busy_o         = busy_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;
    assign int_o          = int_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_ressource_grid_ring_scheduler.sv
// Testbench for ressource_grid_ring_scheduler: directed scenarios plus a
// randomized run against a word-count based reference model.
module tb_ressource_grid_ring_scheduler;

    localparam int N   = 4;
    localparam int S   = 8;
    localparam int THR = 2;
    localparam int SW  = 2;
    localparam int OW  = 3;
    localparam int FW  = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          beat = 1'b0;
    logic          consume = 1'b0;
    logic          clear = 1'b0;
    logic          wr_ready;
    logic [SW-1:0] wr_segment;
    logic [OW-1:0] wr_offset;
    logic [SW-1:0] last_segment;
    logic [FW-1:0] fill_level;
    logic          busy;
    logic          overflow;
    logic          underflow;
    logic          irq;
    logic [1:0]    state;

    int checks = 0;
    int errors = 0;

    // Reference model: position kept as a word count, not as pointers.
    int m_words;
    int m_completed;
    int m_fill;
    int m_state;
    bit m_ovf;
    bit m_unf;
    bit m_int;

    ressource_grid_ring_scheduler #(
        .NUM_SEGMENTS (N),
        .SEGMENT_SIZE (S),
        .INT_THRESHOLD(THR)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .enable_i      (enable),
        .beat_i        (beat),
        .cpu_consume_i (consume),
        .clear_errors_i(clear),
        .wr_ready_o    (wr_ready),
        .wr_segment_o  (wr_segment),
        .wr_offset_o   (wr_offset),
        .last_segment_o(last_segment),
        .fill_level_o  (fill_level),
        .busy_o        (busy),
        .overflow_o    (overflow),
        .underflow_o   (underflow),
        .int_o         (irq),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return (m_state == 1) || (m_state == 2);
    endfunction

    function automatic int m_last();
        return (m_completed == 0) ? N - 1 : (m_completed - 1) % N;
    endfunction

    task automatic model_step(input bit en, input bit bt, input bit cs, input bit cl, input bit rst_n);
        bit valid;
        bit done;
        bit cons_ok;
        int nfill;
        int nstate;
        if (!rst_n) begin
            m_words = 0; m_completed = 0; m_fill = 0; m_state = 0;
            m_ovf = 0; m_unf = 0; m_int = 0;
            return;
        end
        valid   = bt && m_ready();
        done    = valid && (m_words % S == S - 1);
        cons_ok = cs && (m_fill > 0);
        nfill   = m_fill + (done ? 1 : 0) - (cons_ok ? 1 : 0);
        nstate  = m_state;
        case (m_state)
            0: if (en) nstate = 1;
            1: begin
                if (done && nfill == N) nstate = 3;
                else if (!en) nstate = ((m_words % S == 0) && !valid) ? 0 : 2;
            end
            2: begin
                if (done && nfill == N) nstate = 3;
                else if (en) nstate = 1;
                else if (done) nstate = 0;
            end
            default: if (cons_ok) nstate = en ? 1 : 0;
        endcase
        m_int = done && (nfill >= THR);
        if (bt && !m_ready()) m_ovf = 1; else if (cl) m_ovf = 0;
        if (cs && m_fill == 0) m_unf = 1; else if (cl) m_unf = 0;
        if (valid) m_words = (m_words + 1) % (N * S);
        if (done) m_completed++;
        m_fill  = nfill;
        m_state = nstate;
    endtask

    task automatic cycle(input bit en, input bit bt, input bit cs, input bit cl, input bit rst_n);
        enable  = en;
        beat    = bt;
        consume = cs;
        clear   = cl;
        reset_n = rst_n;
        model_step(en, bt, cs, cl, rst_n);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, 0, 0, 0);
        checks++;
        if ({wr_ready, wr_segment, wr_offset, last_segment, fill_level, busy, overflow, underflow, irq, state}
            !== {1'b0, 2'd0, 3'd0, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%0b seg=%0d off=%0d last=%0d fill=%0d busy=%0b ovf=%0b unf=%0b int=%0b st=%0d exp 0 0 0 3 0 0 0 0 0 0",
                     wr_ready, wr_segment, wr_offset, last_segment, fill_level, busy, overflow, underflow, irq, state);
        end
    endtask

    task automatic test_segment_fill();
        int pulses = 0;
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        checks++;
        if (state !== 2'd1 || wr_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL enter_run got st=%0d rdy=%0b busy=%0b exp 1 1 1", state, wr_ready, busy);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0, 0, 1);
            if (irq === 1'b1) pulses++;
        end
        checks++;
        if ({wr_segment, wr_offset, last_segment, fill_level} !== {2'd1, 3'd0, 2'd0, 3'd1} || pulses != 0) begin
            errors++;
            $display("FAIL first_segment got seg=%0d off=%0d last=%0d fill=%0d ints=%0d exp 1 0 0 1 0",
                     wr_segment, wr_offset, last_segment, fill_level, pulses);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 0, 0, 1);
            if (irq === 1'b1) pulses++;
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL int_on_threshold got %0b exp 1", irq);
        end
        cycle(1, 0, 0, 0, 1);
        checks++;
        if (fill_level !== 3'd2 || last_segment !== 2'd1 || irq !== 1'b0 || pulses != 1) begin
            errors++;
            $display("FAIL second_segment got fill=%0d last=%0d int=%0b pulses=%0d exp 2 1 0 1",
                     fill_level, last_segment, irq, pulses);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 1);
        checks++;
        if (fill_level !== 3'd4 || state !== 2'd3 || wr_ready !== 1'b0 || wr_segment !== 2'd0) begin
            errors++;
            $display("FAIL ring_full got fill=%0d st=%0d rdy=%0b seg=%0d exp 4 3 0 0",
                     fill_level, state, wr_ready, wr_segment);
        end
        cycle(1, 1, 0, 0, 1);
        checks++;
        if (overflow !== 1'b1 || wr_segment !== 2'd0 || wr_offset !== 3'd0 || fill_level !== 3'd4) begin
            errors++;
            $display("FAIL overflow_beat got ovf=%0b seg=%0d off=%0d fill=%0d exp 1 0 0 4",
                     overflow, wr_segment, wr_offset, fill_level);
        end
        cycle(1, 0, 1, 0, 1);
        checks++;
        if (fill_level !== 3'd3 || state !== 2'd1 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL leave_full got fill=%0d st=%0d rdy=%0b exp 3 1 1", fill_level, state, wr_ready);
        end
    endtask

    task automatic test_interleaved();
        int max_fill = 0;
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        for (int i = 1; i <= 40; i++) begin
            cycle(1, 1, (i % 8 == 0), 0, 1);
            if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
        end
        checks++;
        if (max_fill > 1 || wr_segment !== 2'd1 || last_segment !== 2'd0 || wr_offset !== 3'd0) begin
            errors++;
            $display("FAIL interleaved got maxfill=%0d seg=%0d last=%0d off=%0d exp <=1 1 0 0",
                     max_fill, wr_segment, last_segment, wr_offset);
        end
    endtask

    task automatic test_errors();
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 1);
        checks++;
        if (underflow !== 1'b1 || fill_level !== 3'd0) begin
            errors++;
            $display("FAIL underflow_set got unf=%0b fill=%0d exp 1 0", underflow, fill_level);
        end
        cycle(0, 0, 0, 1, 1);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear got %0b exp 0", underflow);
        end
        cycle(0, 0, 1, 1, 1);
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear got %0b exp 1", underflow);
        end
        cycle(0, 1, 0, 0, 1);
        checks++;
        if (overflow !== 1'b1 || wr_offset !== 3'd0) begin
            errors++;
            $display("FAIL idle_overflow got ovf=%0b off=%0d exp 1 0", overflow, wr_offset);
        end
    endtask

    task automatic test_drain();
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        checks++;
        if (state !== 2'd2 || wr_ready !== 1'b1 || wr_offset !== 3'd3) begin
            errors++;
            $display("FAIL enter_drain got st=%0d rdy=%0b off=%0d exp 2 1 3", state, wr_ready, wr_offset);
        end
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 1);
        checks++;
        if (state !== 2'd0 || wr_ready !== 1'b0 || busy !== 1'b0 || fill_level !== 3'd1 || wr_segment !== 2'd1) begin
            errors++;
            $display("FAIL drain_done got st=%0d rdy=%0b busy=%0b fill=%0d seg=%0d exp 0 0 0 1 1",
                     state, wr_ready, busy, fill_level, wr_segment);
        end
        cycle(1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        checks++;
        if (state !== 2'd1 || wr_segment !== 2'd1 || wr_offset !== 3'd1) begin
            errors++;
            $display("FAIL reenable got st=%0d seg=%0d off=%0d exp 1 1 1", state, wr_segment, wr_offset);
        end
    endtask

    task automatic test_reset_mid();
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1);
        for (int i = 0; i < 21; i++) cycle(1, 1, 0, 0, 1);
        checks++;
        if (wr_offset !== 3'd5 || fill_level !== 3'd2) begin
            errors++;
            $display("FAIL pre_reset got off=%0d fill=%0d exp 5 2", wr_offset, fill_level);
        end
        cycle(1, 1, 1, 0, 0);
        checks++;
        if ({wr_ready, wr_segment, wr_offset, last_segment, fill_level, busy, overflow, underflow, irq, state}
            !== {1'b0, 2'd0, 3'd0, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL mid_reset got rdy=%0b seg=%0d off=%0d last=%0d fill=%0d busy=%0b int=%0b st=%0d exp 0 0 0 3 0 0 0 0",
                     wr_ready, wr_segment, wr_offset, last_segment, fill_level, busy, irq, state);
        end
    endtask

    task automatic test_random();
        bit en = 1;
        cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) en = ~en;
            cycle(en, ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 18),
                  ($urandom_range(0, 99) < 3), 1);
            checks++;
            if (wr_segment !== SW'(m_words / S) || wr_offset !== OW'(m_words % S) ||
                last_segment !== SW'(m_last()) || fill_level !== FW'(m_fill) ||
                state !== 2'(m_state) || wr_ready !== m_ready() || busy !== (m_state != 0) ||
                overflow !== m_ovf || underflow !== m_unf || irq !== m_int) begin
                errors++;
                $display("FAIL random_cycle_%0d got seg=%0d off=%0d last=%0d fill=%0d st=%0d rdy=%0b ovf=%0b unf=%0b int=%0b exp seg=%0d off=%0d last=%0d fill=%0d st=%0d rdy=%0b ovf=%0b unf=%0b int=%0b",
                         i, wr_segment, wr_offset, last_segment, fill_level, state, wr_ready, overflow, underflow, irq,
                         m_words / S, m_words % S, m_last(), m_fill, m_state, m_ready(), m_ovf, m_unf, m_int);
            end
        end
    endtask

    initial begin
        test_reset();
        test_segment_fill();
        test_full();
        test_interleaved();
        test_errors();
        test_drain();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
